// File: rtl/huffman_stream_ctrl.sv
// Byte-stream front end for the 6-symbol Huffman code (A=0,B=101,C=100,D=111,E=1101,F=1100).
// Unpacks bytes MSB-first, walks the code tree one bit per step and queues symbols in a FIFO.
module huffman_stream_ctrl #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic       in_last,
    input  logic [3:0] in_nbits,
    output logic       sym_valid,
    input  logic       sym_ready,
    output logic [2:0] sym,
    output logic       sym_last,
    output logic       err,
    output logic       busy
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, SHIFT, END} ctrl_t;
    typedef enum logic [2:0] {ROOT, N1, N10, N11, N110} tree_t;

    ctrl_t       state, state_nxt;
    tree_t       tree, tree_nxt;
    logic [7:0]  shreg;
    logic [3:0]  bits_left;
    logic        last_f;
    logic [3:0]  mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count;
    logic [3:0]  head;
    logic [3:0]  nb_eff;
    logic [2:0]  code;
    logic        emit, step, push, pop, bit_in, final_bit;

    assign bit_in    = shreg[7];
    assign step      = (state == SHIFT) && (count != DEPTH_C);
    assign push      = step && emit;
    assign pop       = sym_valid && sym_ready;
    assign final_bit = (bits_left == 4'd1);
    assign nb_eff    = ((in_nbits == 4'd0) || (in_nbits > 4'd8)) ? 4'd8 : in_nbits;

    assign head      = mem[rd_ptr];
    assign in_ready  = (state == IDLE);
    assign sym_valid = (count != '0);
    assign sym       = sym_valid ? head[3:1] : '0;
    assign sym_last  = sym_valid & head[0];
    assign busy      = (state != IDLE) || (count != '0);

    always_comb begin
        tree_nxt = tree;
        emit     = 1'b0;
        code     = '0;
        case (tree)
            ROOT: begin
                if (bit_in) begin
                    tree_nxt = N1;
                end else begin
                    emit = 1'b1;
                    code = 3'd1;
                end
            end
            N1:   tree_nxt = bit_in ? N11 : N10;
            N10: begin
                emit     = 1'b1;
                code     = bit_in ? 3'd2 : 3'd3;
                tree_nxt = ROOT;
            end
            N11: begin
                if (bit_in) begin
                    emit     = 1'b1;
                    code     = 3'd4;
                    tree_nxt = ROOT;
                end else begin
                    tree_nxt = N110;
                end
            end
            N110: begin
                emit     = 1'b1;
                code     = bit_in ? 3'd5 : 3'd6;
                tree_nxt = ROOT;
            end
            default: tree_nxt = ROOT;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = SHIFT;
            SHIFT:   if (step && final_bit) state_nxt = last_f ? END : IDLE;
            END:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            tree      <= ROOT;
            shreg     <= '0;
            bits_left <= '0;
            last_f    <= 1'b0;
            err       <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        shreg     <= in_data;
                        bits_left <= in_last ? nb_eff : 4'd8;
                        last_f    <= in_last;
                        err       <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (step) begin
                        shreg     <= {shreg[6:0], 1'b0};
                        bits_left <= bits_left - 4'd1;
                        tree      <= tree_nxt;
                    end
                end
                END: begin
                    // A packet that ends inside a codeword drops the partial symbol.
                    if (tree != ROOT) begin
                        err  <= 1'b1;
                        tree <= ROOT;
                    end
                end
                default: ;
            endcase
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW + 1)'(push) - (AW + 1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {code, last_f & final_bit};
    end
endmodule
